// File: rtl/pcie_reset_sequencer_pkg.sv
// Shared definitions for the PCIe reset sequencer: one-hot FSM encoding and
// helpers that size the internal counters from the cycle parameters.
package pcie_reset_sequencer_pkg;

  // One-hot sequencer states
  typedef enum logic [4:0] {
    S_HOLD     = 5'b00001,
    S_WAIT_LNK = 5'b00010,
    S_RELEASE  = 5'b00100,
    S_RUN      = 5'b01000,
    S_SWRST    = 5'b10000
  } state_e;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pcie_reset_sequencer_timer.sv
// Loadable down-counter shared by the sequencer's timed states.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   value loaded; the count stops at zero
//   zero_o       registered flag, high while the count is zero
module pcie_reset_sequencer_timer #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Next count: load wins, otherwise decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= W'(RST_VAL);
      zero_q <= (RST_VAL == 0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/pcie_reset_sequencer.sv
// Multi-channel reset sequencer for the PCIe endpoint clock domain.
// Holds all channels in reset, debounces link-up, then releases channels one
// at a time (bit 0 first), and re-asserts everything on link drop or on a
// software reset request.
// Ports:
//   clk250         endpoint clock
//   trn_reset_n    asynchronous active-low reset
//   trn_lnk_up_n   link up (active low), synchronous to clk250
//   sw_reset_req   single-cycle software reset request
//   reset_out      active-high channel resets, registered
//   rst_done       high when every channel is released, registered
//   link_drop_cnt  saturating count of link drops seen in S_RELEASE/S_RUN
module pcie_reset_sequencer
  import pcie_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_RST       = 4,
  parameter int unsigned PRE_CYCLES    = 5,
  parameter int unsigned LNK_STABLE    = 16,
  parameter int unsigned STAGGER       = 8,
  parameter int unsigned SW_RST_CYCLES = 32,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk250,
  input  logic               trn_reset_n,
  input  logic               trn_lnk_up_n,
  input  logic               sw_reset_req,
  output logic [NUM_RST-1:0] reset_out,
  output logic               rst_done,
  output logic [CNT_W-1:0]   link_drop_cnt
);

  localparam int unsigned TMR_W = cnt_width(max3(PRE_CYCLES, STAGGER, SW_RST_CYCLES));
  localparam int unsigned DBC_W = cnt_width(LNK_STABLE);
  localparam int unsigned IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  state_e             state_q, state_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DBC_W-1:0]   dbc_q, dbc_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;

  // Reset value covers the first edge after trn_reset_n rises; entries made
  // by a transition load N-1 so the state lasts N edges.
  pcie_reset_sequencer_timer #(
    .W       (TMR_W),
    .RST_VAL (PRE_CYCLES)
  ) u_timer (
    .clk        (clk250),
    .rst_n      (trn_reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    rst_d      = rst_q;
    done_d     = done_q;
    drop_cnt_d = drop_cnt_q;
    idx_d      = idx_q;
    dbc_d      = dbc_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      S_HOLD: begin
        if (tmr_zero) begin
          state_d = S_WAIT_LNK;
          dbc_d   = '0;
        end
      end

      S_WAIT_LNK: begin
        if (trn_lnk_up_n) begin
          dbc_d = '0;
        end else if (dbc_q == DBC_W'(LNK_STABLE - 1)) begin
          rst_d[0] = 1'b0;
          dbc_d    = DBC_W'(LNK_STABLE);
          idx_d    = '0;
          if (NUM_RST == 1) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d  = S_RELEASE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STAGGER - 1);
          end
        end else begin
          dbc_d = dbc_q + DBC_W'(1);
        end
      end

      S_RELEASE, S_RUN: begin
        if (trn_lnk_up_n) begin
          // Link drop takes priority over a coincident software request
          rst_d    = '1;
          done_d   = 1'b0;
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PRE_CYCLES - 1);
          if (drop_cnt_q != {CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end else if (sw_reset_req) begin
          rst_d    = '1;
          done_d   = 1'b0;
          state_d  = S_SWRST;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SW_RST_CYCLES - 1);
        end else if (state_q == S_RELEASE && tmr_zero) begin
          // Lower bits are already clear, so a left shift clears the next one
          rst_d = rst_q << 1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_RST - 2)) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STAGGER - 1);
          end
        end
      end

      S_SWRST: begin
        if (tmr_zero) begin
          state_d = S_WAIT_LNK;
          dbc_d   = '0;
        end
      end

      default: begin
        state_d  = S_HOLD;
        rst_d    = '1;
        done_d   = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(PRE_CYCLES - 1);
      end
    endcase
  end

  always_ff @(posedge clk250 or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q    <= S_HOLD;
      rst_q      <= '1;
      done_q     <= 1'b0;
      drop_cnt_q <= '0;
      idx_q      <= '0;
      dbc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_q      <= rst_d;
      done_q     <= done_d;
      drop_cnt_q <= drop_cnt_d;
      idx_q      <= idx_d;
      dbc_q      <= dbc_d;
    end
  end

  assign reset_out     = rst_q;
  assign rst_done      = done_q;
  assign link_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// Self-checking bench for pcie_reset_sequencer with default parameters.
// Expected output snapshots are queued against an edge number (edge 0 = first
// edge with trn_reset_n high) and compared on the following falling edge.
module tb_pcie_reset_sequencer;

  logic       clk250 = 1'b0;
  logic       trn_reset_n;
  logic       trn_lnk_up_n;
  logic       sw_reset_req;
  logic [3:0] reset_out;
  logic       rst_done;
  logic [7:0] link_drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int last_edge;

  typedef struct {
    int         e;
    logic [3:0] ro;
    logic       done;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  pcie_reset_sequencer #(
    .NUM_RST       (4),
    .PRE_CYCLES    (5),
    .LNK_STABLE    (16),
    .STAGGER       (8),
    .SW_RST_CYCLES (32),
    .CNT_W         (8)
  ) dut (
    .clk250        (clk250),
    .trn_reset_n   (trn_reset_n),
    .trn_lnk_up_n  (trn_lnk_up_n),
    .sw_reset_req  (sw_reset_req),
    .reset_out     (reset_out),
    .rst_done      (rst_done),
    .link_drop_cnt (link_drop_cnt)
  );

  always #5 clk250 = ~clk250;

  always @(posedge clk250 or negedge trn_reset_n) begin
    if (!trn_reset_n) last_edge <= -1;
    else              last_edge <= last_edge + 1;
  end

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int e, input logic [3:0] ro, input logic done,
                           input logic [7:0] cnt, input string tag);
    exp_t x;
    x.e = e; x.ro = ro; x.done = done; x.cnt = cnt; x.tag = tag;
    sb.push_back(x);
  endtask

  // Staggered release whose bit 0 falls at edge base
  task automatic expect_release(input int base, input logic [7:0] cnt, input string tag);
    expect_at(base - 1,  4'hF, 1'b0, cnt, {tag, "_pre"});
    expect_at(base,      4'hE, 1'b0, cnt, {tag, "_b0"});
    expect_at(base + 7,  4'hE, 1'b0, cnt, {tag, "_b0hold"});
    expect_at(base + 8,  4'hC, 1'b0, cnt, {tag, "_b1"});
    expect_at(base + 15, 4'hC, 1'b0, cnt, {tag, "_b1hold"});
    expect_at(base + 16, 4'h8, 1'b0, cnt, {tag, "_b2"});
    expect_at(base + 23, 4'h8, 1'b0, cnt, {tag, "_b2hold"});
    expect_at(base + 24, 4'h0, 1'b1, cnt, {tag, "_b3done"});
  endtask

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (last_edge < n && guard < 20000) begin
      @(negedge clk250);
      guard++;
    end
    if (last_edge < n) check("wait_edge_timeout", 13'(last_edge), 13'(n));
  endtask

  // Ordering rule and scoreboard comparison on every falling edge
  always @(negedge clk250) begin
    logic [3:0] inv;
    exp_t       x;
    inv = ~reset_out;
    check("bit_order", {9'd0, inv & (inv + 4'd1)}, 13'd0);
    while (trn_reset_n && sb.size() > 0 && sb[0].e <= last_edge) begin
      x = sb.pop_front();
      if (x.e != last_edge) begin
        check({x.tag, "_missed"}, 13'(last_edge), 13'(x.e));
      end else begin
        check(x.tag, {reset_out, rst_done, link_drop_cnt}, {x.ro, x.done, x.cnt});
      end
    end
  end

  initial begin
    int         exp_cnt;
    int         guard;
    logic [7:0] exp_cnt8;

    trn_reset_n  = 1'b0;
    trn_lnk_up_n = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) @(negedge clk250);
    check("reset_state", {reset_out, rst_done, link_drop_cnt}, {4'hF, 1'b0, 8'h00});

    // Test 1: link up throughout; a software request during debounce is ignored
    expect_at(5, 4'hF, 1'b0, 8'h00, "t1_hold");
    expect_release(21, 8'h00, "t1");
    trn_reset_n = 1'b1;
    wait_edge(9);
    sw_reset_req = 1'b1;
    wait_edge(10);
    sw_reset_req = 1'b0;
    wait_edge(50);

    // Test 3: one-cycle link drop in S_RUN, then full resequence
    trn_lnk_up_n = 1'b1;
    expect_at(51, 4'hF, 1'b0, 8'h01, "t3_drop");
    expect_release(72, 8'h01, "t3");
    wait_edge(51);
    trn_lnk_up_n = 1'b0;
    wait_edge(100);

    // Test 4: software reset pulse in S_RUN
    sw_reset_req = 1'b1;
    expect_at(101, 4'hF, 1'b0, 8'h01, "t4_swrst");
    expect_at(120, 4'hF, 1'b0, 8'h01, "t4_swhold");
    expect_release(149, 8'h01, "t4");
    wait_edge(101);
    sw_reset_req = 1'b0;
    wait_edge(180);

    // Test 2: glitch during debounce restarts the stable count
    trn_lnk_up_n = 1'b1;
    expect_at(181, 4'hF, 1'b0, 8'h02, "t2_drop");
    expect_at(205, 4'hF, 1'b0, 8'h02, "t2_no_early_release");
    expect_release(216, 8'h02, "t2");
    wait_edge(189);
    trn_lnk_up_n = 1'b0;
    wait_edge(199);
    trn_lnk_up_n = 1'b1;
    wait_edge(200);
    trn_lnk_up_n = 1'b0;
    wait_edge(250);

    // Test 5a: link drop and software request together -> link-drop path
    trn_lnk_up_n = 1'b1;
    sw_reset_req = 1'b1;
    expect_at(251, 4'hF, 1'b0, 8'h03, "t5_both");
    expect_release(272, 8'h03, "t5");
    wait_edge(251);
    trn_lnk_up_n = 1'b0;
    sw_reset_req = 1'b0;
    wait_edge(300);

    // Test 5b: asynchronous reset in the middle of S_RELEASE
    trn_lnk_up_n = 1'b1;
    expect_at(301, 4'hF, 1'b0, 8'h04, "t5b_drop");
    expect_at(321, 4'hF, 1'b0, 8'h04, "t5b_pre");
    expect_at(322, 4'hE, 1'b0, 8'h04, "t5b_b0");
    expect_at(330, 4'hC, 1'b0, 8'h04, "t5b_b1");
    wait_edge(301);
    trn_lnk_up_n = 1'b0;
    wait_edge(330);
    #1;
    trn_reset_n = 1'b0;
    #1;
    check("t5b_async_reset", {reset_out, rst_done, link_drop_cnt}, {4'hF, 1'b0, 8'h00});
    repeat (2) @(negedge clk250);

    // Test 6: 300 link drops, count saturates
    trn_reset_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      guard = 0;
      while (reset_out[0] !== 1'b0 && guard < 60) begin
        @(negedge clk250);
        guard++;
      end
      if (reset_out[0] !== 1'b0) begin
        check("t6_release_timeout", {12'd0, reset_out[0]}, 13'd0);
        break;
      end
      exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      exp_cnt8 = 8'(exp_cnt);
      trn_lnk_up_n = 1'b1;
      expect_at(last_edge + 1, 4'hF, 1'b0, exp_cnt8, "t6_drop");
      @(negedge clk250);
      trn_lnk_up_n = 1'b0;
    end
    @(negedge clk250);
    check("t6_saturated", {5'd0, link_drop_cnt}, {5'd0, 8'hFF});

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk250);
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check({x.tag, "_never_reached"}, 13'(last_edge), 13'(x.e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
